// File: rtl/sb_msg_responder.sv
// Sideband training responder: queues decoded request messages and returns the
// matching response (code|1, info echoed) after a programmable head delay.
module sb_msg_responder #(
  parameter int         DEPTH          = 4,
  parameter int         RESP_DELAY     = 2,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] REQ_MIN        = 8'h10,
  parameter logic [7:0] REQ_MAX        = 8'h3E
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic                   rx_msg_valid_i,
  input  logic [7:0]             rx_msg_code_i,
  input  logic [15:0]            rx_msg_info_i,
  output logic                   tx_msg_valid_o,
  output logic [7:0]             tx_msg_code_o,
  output logic [15:0]            tx_msg_info_o,
  input  logic                   tx_msg_ready_i,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic                   overflow_o,
  output logic                   timeout_o,
  output logic [7:0]             drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  // Entries are kept in registers because every slot is compared for duplicates.
  logic [7:0]    codeMem [DEPTH];
  logic [15:0]   infoMem [DEPTH];
  logic [AW-1:0] rdPtrReg;
  logic [AW-1:0] wrPtrReg;
  logic [CW-1:0] countReg;
  logic [DW-1:0] delayCntReg;
  logic [TW-1:0] stallCntReg;
  logic          txValidReg;
  logic [7:0]    txCodeReg;
  logic [15:0]   txInfoReg;
  logic          overflowReg;
  logic          timeoutReg;
  logic [7:0]    dropCntReg;

  logic             isRequest;
  logic             accept;
  logic [7:0]       respCode;
  logic             handshake;
  logic             timeoutHit;
  logic             pop;
  logic [DEPTH-1:0] dupHit;
  logic             isDup;
  logic [CW-1:0]    countAfterPop;
  logic             isFull;
  logic             push;
  logic             dropReq;
  logic [CW-1:0]    countNext;
  logic             newHead;
  logic             presentNow;
  logic [1:0]       dropInc;
  logic [8:0]       dropSum;
  logic [7:0]       dropCntNext;

  assign isRequest = ~rx_msg_code_i[0] && (rx_msg_code_i >= REQ_MIN) && (rx_msg_code_i <= REQ_MAX);
  assign accept    = enable_i & rx_msg_valid_i & isRequest;
  assign respCode  = rx_msg_code_i | 8'h01;
  assign handshake = txValidReg & tx_msg_ready_i;

  generate
    if (TIMEOUT_EN) begin : gTimeout
      assign timeoutHit = txValidReg & ~tx_msg_ready_i &
                          (stallCntReg == TW'(TIMEOUT_CYCLES - 1));
    end else begin : gNoTimeout
      assign timeoutHit = 1'b0;
    end
  endgenerate

  assign pop = enable_i & (handshake | timeoutHit);

  // A slot is live when its distance from the head is below the occupancy;
  // the entry leaving on this edge does not block a new identical request.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
    logic [AW-1:0] slotOffset;
    logic          slotValid;
    assign slotOffset = AW'(gi) - rdPtrReg;
    assign slotValid  = ({1'b0, slotOffset} < countReg);
    assign dupHit[gi] = slotValid && (codeMem[gi] == respCode) &&
                        !(pop && (rdPtrReg == AW'(gi)));
  end

  assign isDup         = |dupHit;
  assign countAfterPop = countReg - CW'(pop);
  assign isFull        = (countAfterPop == CW'(DEPTH));
  assign push          = accept & ~isDup & ~isFull;
  assign dropReq       = accept & (isDup | isFull);
  assign countNext     = countAfterPop + CW'(push);
  assign newHead       = ((countReg == '0) && push) || (pop && (countNext != '0));
  assign presentNow    = ~txValidReg && (countReg != '0) && (delayCntReg == '0);

  assign dropInc     = {1'b0, dropReq} + {1'b0, timeoutHit};
  assign dropSum     = {1'b0, dropCntReg} + {7'b0, dropInc};
  assign dropCntNext = dropSum[8] ? 8'hFF : dropSum[7:0];

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        codeMem[i] <= '0;
        infoMem[i] <= '0;
      end
    end else if (push) begin
      codeMem[wrPtrReg] <= respCode;
      infoMem[wrPtrReg] <= rx_msg_info_i;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      countReg    <= '0;
      delayCntReg <= '0;
      stallCntReg <= '0;
      txValidReg  <= 1'b0;
      txCodeReg   <= '0;
      txInfoReg   <= '0;
      overflowReg <= 1'b0;
      timeoutReg  <= 1'b0;
      dropCntReg  <= '0;
    end else if (!enable_i) begin
      // Flush: queue and handshake state cleared, error history retained.
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      countReg    <= '0;
      delayCntReg <= '0;
      stallCntReg <= '0;
      txValidReg  <= 1'b0;
      txCodeReg   <= '0;
      txInfoReg   <= '0;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + AW'(1);
      if (pop)  rdPtrReg <= rdPtrReg + AW'(1);
      countReg <= countNext;

      if (newHead)                 delayCntReg <= DW'(RESP_DELAY);
      else if (delayCntReg != '0)  delayCntReg <= delayCntReg - DW'(1);

      if (pop)
        stallCntReg <= '0;
      else if (TIMEOUT_EN && txValidReg && !tx_msg_ready_i)
        stallCntReg <= stallCntReg + TW'(1);

      if (pop) begin
        txValidReg <= 1'b0;
        txCodeReg  <= '0;
        txInfoReg  <= '0;
      end else if (presentNow) begin
        txValidReg <= 1'b1;
        txCodeReg  <= codeMem[rdPtrReg];
        txInfoReg  <= infoMem[rdPtrReg];
      end

      if (accept && !isDup && isFull) overflowReg <= 1'b1;
      if (timeoutHit)                 timeoutReg  <= 1'b1;
      dropCntReg <= dropCntNext;
    end
  end

  assign tx_msg_valid_o = txValidReg;
  assign tx_msg_code_o  = txCodeReg;
  assign tx_msg_info_o  = txInfoReg;
  assign pending_o      = countReg;
  assign overflow_o     = overflowReg;
  assign timeout_o      = timeoutReg;
  assign drop_cnt_o     = dropCntReg;

endmodule

// File: tb/tb_sb_msg_responder.sv
// Bench for sb_msg_responder: directed scenarios followed by random traffic, every
// cycle compared against a queue-based model of the request/response rules.
module tb_sb_msg_responder;

  localparam int DEPTH          = 4;
  localparam int RESP_DELAY     = 2;
  localparam int TIMEOUT_CYCLES = 5;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        enable_i = 1'b0;
  logic        rx_msg_valid_i = 1'b0;
  logic [7:0]  rx_msg_code_i = '0;
  logic [15:0] rx_msg_info_i = '0;
  logic        tx_msg_ready_i = 1'b0;
  logic        tx_msg_valid_o;
  logic [7:0]  tx_msg_code_o;
  logic [15:0] tx_msg_info_o;
  logic [2:0]  pending_o;
  logic        overflow_o;
  logic        timeout_o;
  logic [7:0]  drop_cnt_o;

  sb_msg_responder #(
    .DEPTH(DEPTH), .RESP_DELAY(RESP_DELAY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .REQ_MIN(8'h10), .REQ_MAX(8'h3E)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .enable_i(enable_i),
    .rx_msg_valid_i(rx_msg_valid_i), .rx_msg_code_i(rx_msg_code_i),
    .rx_msg_info_i(rx_msg_info_i), .tx_msg_valid_o(tx_msg_valid_o),
    .tx_msg_code_o(tx_msg_code_o), .tx_msg_info_o(tx_msg_info_o),
    .tx_msg_ready_i(tx_msg_ready_i), .pending_o(pending_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int nChecks = 0;
  int nPass = 0;

  // Reference model state
  logic [23:0] mQ[$];
  bit          mValid;
  logic [7:0]  mCode;
  logic [15:0] mInfo;
  int          mStall;
  bit          mOverflow;
  bit          mTimeout;
  int          mDrop;
  int          edgeNum = 0;
  int          presentEdge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mQ.delete();
    mValid = 0; mCode = '0; mInfo = '0; mStall = 0;
    mOverflow = 0; mTimeout = 0; mDrop = 0; presentEdge = 0;
  endtask

  // Rules: pop first (handshake or timeout), then classify the request against
  // what remains; a new head becomes visible 1+RESP_DELAY edges after it forms.
  task automatic modelEdge();
    bit pop, tmo, setValid, isReq, dup;
    int oldSize, drops;
    logic [7:0] resp;
    edgeNum++;
    if (!enable_i) begin
      mQ.delete(); mValid = 0; mStall = 0;
      return;
    end
    oldSize  = mQ.size();
    setValid = !mValid && oldSize > 0 && edgeNum >= presentEdge;
    pop = 0; tmo = 0;
    if (mValid && tx_msg_ready_i) pop = 1;
    else if (mValid && TIMEOUT_CYCLES > 0) begin
      mStall++;
      if (mStall == TIMEOUT_CYCLES) begin pop = 1; tmo = 1; end
    end
    if (pop) begin mQ.delete(0); mValid = 0; mStall = 0; end
    drops = tmo ? 1 : 0;
    isReq = (rx_msg_code_i[0] == 1'b0) && rx_msg_code_i >= 8'h10 && rx_msg_code_i <= 8'h3E;
    if (rx_msg_valid_i && isReq) begin
      resp = rx_msg_code_i | 8'h01;
      dup = 0;
      foreach (mQ[i]) if (mQ[i][23:16] == resp) dup = 1;
      if (dup) drops++;
      else if (mQ.size() == DEPTH) begin drops++; mOverflow = 1; end
      else mQ.push_back({resp, rx_msg_info_i});
    end
    if (tmo) mTimeout = 1;
    mDrop = (mDrop + drops > 255) ? 255 : mDrop + drops;
    if (mQ.size() > 0 && (oldSize == 0 || pop)) presentEdge = edgeNum + 1 + RESP_DELAY;
    if (setValid) begin mValid = 1; mCode = mQ[0][23:16]; mInfo = mQ[0][15:0]; end
  endtask

  task automatic compareAll();
    chk("model_valid", tx_msg_valid_o, mValid);
    if (mValid) begin
      chk("model_code", tx_msg_code_o, mCode);
      chk("model_info", tx_msg_info_o, mInfo);
    end
    chk("model_pending", pending_o, mQ.size());
    chk("model_overflow", overflow_o, mOverflow);
    chk("model_timeout", timeout_o, mTimeout);
    chk("model_drop", drop_cnt_o, mDrop);
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic send(input logic [7:0] code, input logic [15:0] info);
    rx_msg_valid_i = 1'b1; rx_msg_code_i = code; rx_msg_info_i = info;
    step();
    rx_msg_valid_i = 1'b0;
  endtask

  task automatic waitValid(input int maxCycles, output int n);
    n = 0;
    while (!tx_msg_valid_o && n < maxCycles) begin step(); n++; end
    chk("wait_valid_bound", tx_msg_valid_o, 1'b1);
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    tx_msg_ready_i = 1'b1;
    while (pending_o != 0 && n < maxCycles) begin step(); n++; end
    chk("drain_bound", pending_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int n;
    int rdyPct;
    logic [7:0] hsCode[$];
    int hsEdge[$];
    logic [7:0] expCodes[4];

    modelReset();
    #12;
    chk("reset_valid", tx_msg_valid_o, 1'b0);
    chk("reset_pending", pending_o, 0);
    chk("reset_drop", drop_cnt_o, 0);
    chk("reset_flags", {overflow_o, timeout_o}, 2'b00);
    reset = 1'b0;
    enable_i = 1'b1;

    // Basic request with ready high
    tx_msg_ready_i = 1'b1;
    send(8'h12, 16'hABCD);
    chk("basic_pending1", pending_o, 1);
    step(); chk("basic_e1_valid", tx_msg_valid_o, 1'b0);
    step(); chk("basic_e2_valid", tx_msg_valid_o, 1'b0);
    step(); chk("basic_e3_valid", tx_msg_valid_o, 1'b1);
    chk("basic_code", tx_msg_code_o, 8'h13);
    chk("basic_info", tx_msg_info_o, 16'hABCD);
    step(); chk("basic_done_valid", tx_msg_valid_o, 1'b0);
    chk("basic_pending0", pending_o, 0);

    // Non-requests are ignored silently
    send(8'h13, 16'h0001);
    send(8'h40, 16'h0002);
    send(8'h0E, 16'h0003);
    repeat (4) step();
    chk("nonreq_pending", pending_o, 0);
    chk("nonreq_drop", drop_cnt_o, 0);
    chk("nonreq_valid", tx_msg_valid_o, 1'b0);

    // Request arriving on handshake edge while full is accepted
    tx_msg_ready_i = 1'b0;
    send(8'h10, 16'h1000); send(8'h14, 16'h1400);
    send(8'h18, 16'h1800); send(8'h1C, 16'h1C00);
    chk("fullpop_pending4", pending_o, 4);
    waitValid(10, n);
    tx_msg_ready_i = 1'b1;
    send(8'h24, 16'h2400);
    chk("fullpop_pending", pending_o, 4);
    chk("fullpop_overflow", overflow_o, 1'b0);
    chk("fullpop_drop", drop_cnt_o, 0);
    drain(40);

    // Duplicate request while pending
    tx_msg_ready_i = 1'b0;
    send(8'h22, 16'h2200);
    send(8'h22, 16'h2201);
    chk("dup_drop", drop_cnt_o, 1);
    chk("dup_pending", pending_o, 1);
    tx_msg_ready_i = 1'b1;
    hsCode.delete();
    repeat (10) begin
      if (tx_msg_valid_o) hsCode.push_back(tx_msg_code_o);
      step();
    end
    chk("dup_resp_count", hsCode.size(), 1);
    if (hsCode.size() > 0) chk("dup_resp_code", hsCode[0], 8'h23);

    // Fill and overflow, then drain in order
    tx_msg_ready_i = 1'b0;
    send(8'h10, 16'h0010); send(8'h14, 16'h0014); send(8'h18, 16'h0018);
    send(8'h1C, 16'h001C); send(8'h20, 16'h0020);
    chk("ovf_pending", pending_o, 4);
    chk("ovf_flag", overflow_o, 1'b1);
    chk("ovf_drop", drop_cnt_o, 2);
    tx_msg_ready_i = 1'b1;
    hsCode.delete(); hsEdge.delete();
    n = 0;
    while (pending_o != 0 && n < 40) begin
      if (tx_msg_valid_o) begin hsCode.push_back(tx_msg_code_o); hsEdge.push_back(edgeNum + 1); end
      step(); n++;
    end
    expCodes = '{8'h11, 8'h15, 8'h19, 8'h1D};
    chk("ovf_resp_count", hsCode.size(), 4);
    for (int i = 0; i < 4 && i < hsCode.size(); i++) chk("ovf_resp_order", hsCode[i], expCodes[i]);
    for (int i = 1; i < hsEdge.size(); i++)
      chk("ovf_resp_spacing", (hsEdge[i] - hsEdge[i-1]) >= RESP_DELAY + 1, 1'b1);

    // Timeout with ready held low
    tx_msg_ready_i = 1'b0;
    send(8'h30, 16'h0030);
    send(8'h34, 16'h0034);
    waitValid(10, n);
    n = 0;
    while (tx_msg_valid_o && n < 20) begin step(); n++; end
    chk("tmo_valid_edges", n, TIMEOUT_CYCLES);
    chk("tmo_flag", timeout_o, 1'b1);
    chk("tmo_pending", pending_o, 1);
    chk("tmo_drop", drop_cnt_o, 3);
    waitValid(10, n);
    chk("tmo_next_latency", n, RESP_DELAY + 1);
    chk("tmo_next_code", tx_msg_code_o, 8'h35);
    drain(20);

    // Flush via enable
    tx_msg_ready_i = 1'b0;
    send(8'h12, 16'h0012); send(8'h16, 16'h0016); send(8'h1A, 16'h001A);
    chk("flush_pending3", pending_o, 3);
    enable_i = 1'b0;
    step();
    chk("flush_pending", pending_o, 0);
    chk("flush_valid", tx_msg_valid_o, 1'b0);
    chk("flush_flags", {overflow_o, timeout_o}, 2'b11);
    chk("flush_drop", drop_cnt_o, 3);
    enable_i = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-handshake
    send(8'h12, 16'h5555);
    waitValid(10, n);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", tx_msg_valid_o, 1'b0);
    chk("areset_code", tx_msg_code_o, 8'h00);
    chk("areset_info", tx_msg_info_o, 16'h0000);
    chk("areset_pending", pending_o, 0);
    chk("areset_flags", {overflow_o, timeout_o}, 2'b00);
    chk("areset_drop", drop_cnt_o, 0);
    modelReset();
    repeat (2) @(posedge clk_100MHz);
    #3 reset = 1'b0;
    repeat (6) step();

    // Random traffic against the model
    rdyPct = 50;
    for (int c = 0; c < 600; c++) begin
      if (c % 32 == 0) rdyPct = ($urandom_range(0, 2) == 0) ? 5 : (($urandom_range(0, 1) == 0) ? 50 : 95);
      enable_i       = ($urandom_range(0, 40) != 0);
      rx_msg_valid_i = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 7) rx_msg_code_i = 8'(8'h10 + 2 * $urandom_range(0, 5));
      else rx_msg_code_i = 8'($urandom_range(0, 255));
      rx_msg_info_i  = 16'($urandom);
      tx_msg_ready_i = ($urandom_range(0, 99) < rdyPct);
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
